ux607_reset_sequencer: RTL and testbench
========================================

# ux607_reset_sequencer

Controls the release order of the core's synchronized reset domains. It holds all domain resets asserted for a minimum time after power-on or after any reset request, then releases them one at a time at fixed intervals. Sources are software, watchdog and debug (ndmreset). It sits between the reset-request sources and the per-domain reset catch-and-sync cells, and records the cause of the last reset sequence.

## Interface
- NDOM, 3 — number of reset domains; bit 0 is released first.
- HOLD, 16 — cycles all domains stay asserted before bit 0 releases; HOLD ≥ 1.
- GAP, 4 — cycles between consecutive domain releases; GAP ≥ 1.
- CNTW, 8 — counter width; must satisfy 2^CNTW > max(HOLD, GAP).

- clock  in  1  — single clock for all logic.
- reset_n  in  1  — reset, synchronous and active-low.
- test_mode  in  1  — DFT bypass; static during test.
- io_req_sw  in  1  — software reset request, sampled every cycle, level or pulse.
- io_req_wdt  in  1  — watchdog reset request.
- io_req_dbg  in  1  — debug ndmreset request.
- io_rst  out  NDOM  — per-domain reset, active-high.
- io_cause  out  3  — cause of the latest sequence: [0]=sw, [1]=wdt, [2]=dbg; 000 means power-on.
- io_busy  out  1  — high while any io_rst bit is asserted by the FSM.
- io_done  out  1  — one-cycle pulse when the last domain releases.

## Operation
- Registered state:
  - FSM state in {ASSERT, RELEASE, RUN};
  - counter cnt[CNTW-1:0];
  - domain index idx (0..NDOM-1);
  - rst_q[NDOM-1:0];
  - cause_q[2:0];
  - done_q.
- req = io_req_sw | io_req_wdt | io_req_dbg; reqv = {dbg, wdt, sw}.
- reset_n low at an edge sets:
  - state=ASSERT, cnt=0, idx=0;
  - rst_q=all ones, cause_q=000, done_q=0.
  - Reset has priority over all requests.
- ASSERT:
  - If req: cnt=0 and cause_q |= reqv (hold restarts; causes accumulate).
  - Else if cnt==HOLD-1: go to RELEASE, clear rst_q[0], set idx=1 and cnt=0.
    - If NDOM==1, go directly to RUN and set done_q.
  - Else cnt+1.
- RELEASE:
  - If req: go to ASSERT, rst_q=all ones, cnt=0, cause_q=reqv (replaced, not OR-ed).
  - Else if cnt==GAP-1: clear rst_q[idx], set idx+1 and cnt=0.
    - If idx==NDOM-1, go to RUN and set done_q.
  - Else cnt+1.
- RUN:
  - If req: go to ASSERT, rst_q=all ones, cnt=0, cause_q=reqv.
  - Requests seen in RUN are never lost.
- done_q is set only on the edge that clears the last bit. It clears on the next edge. An aborted sequence produces no done pulse.
- Release order is monotonic: rst_q[i] may be 0 only if rst_q[j] is 0 for all j<i.
- Reassertion clears all bits on the same edge.
- Outputs:
  - io_rst = test_mode ? {NDOM{~reset_n}} : rst_q, purely combinational in bypass;
  - io_busy = |rst_q;
  - io_cause = cause_q;
  - io_done = done_q.
- The FSM keeps running in test_mode; only io_rst is bypassed.

## Timing
- Let E0 be the first edge with reset_n=1 and no request, with cnt counted from 0.
  - io_rst[0] falls after edge E0+HOLD-1, i.e. it is low from cycle E0+HOLD.
  - io_rst[i] is low from cycle E0+HOLD+i·GAP.
  - io_done is high for exactly the cycle in which io_rst first becomes all zero.
- Request-to-reassert latency: 1 cycle. A req sampled high at edge E sets io_rst=all ones from E onward.
- Requests held high keep the FSM in ASSERT with cnt=0. Release starts HOLD cycles after the edge at which req was last seen high.
- GAP=1: domains release on consecutive cycles. HOLD=1: bit 0 releases one cycle after the hold starts.
- All outputs after reset: io_rst=all ones, io_busy=1, io_cause=000, io_done=0. In bypass, io_rst=all ones while reset_n=0.

## Test plan
- **Power-on** (defaults): reset_n=0 for 5 cycles, then 1 from edge E0.
  - Required: io_rst=111 until it goes 110 at E0+16, 100 at E0+20 and 000 at E0+24.
  - io_done=1 only at E0+24; io_cause=000.
- **Watchdog in RUN**: a one-cycle io_req_wdt pulse at edge E.
  - Required: io_rst=111 and io_busy=1 from E; io_cause=010.
  - Releases at E+16, E+20, E+24, followed by one done pulse.
- **Software request mid-RELEASE** (io_rst=110): pulse io_req_sw.
  - Required: io_rst=111 next cycle; io_cause=001; hold restarts at full 16 cycles.
  - No io_done pulse from the aborted sequence.
- **Simultaneous requests in ASSERT**: at cnt=10 after a wdt-caused reset, pulse io_req_dbg and io_req_sw together.
  - Required: io_cause=111; bit 0 releases 16 cycles after the pulse.
- **reset_n mid-RELEASE**: drive reset_n=0 for 1 cycle while io_rst=100 and io_cause=010.
  - Required: io_rst=111 and io_cause=000 from that edge; full power-on timing follows.
- **Test mode**: test_mode=1 during RUN, toggling reset_n.
  - Required: io_rst=111 in the same cycle reset_n=0 and 000 when reset_n=1, with no dependence on FSM state.

Source files
------------

// File: rtl/ux607_reset_sequencer.sv
// Reset sequencer: holds every reset domain asserted for HOLD cycles, then releases
// domains in ascending order, GAP cycles apart, and records what caused the sequence.
module ux607_reset_sequencer #(
  parameter int unsigned NDOM = 3,
  parameter int unsigned HOLD = 16,
  parameter int unsigned GAP  = 4,
  parameter int unsigned CNTW = 8
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            test_mode,
  input  logic            io_req_sw,
  input  logic            io_req_wdt,
  input  logic            io_req_dbg,
  output logic [NDOM-1:0] io_rst,
  output logic [2:0]      io_cause,
  output logic            io_busy,
  output logic            io_done
);

  localparam int unsigned IDXW = (NDOM > 1) ? $clog2(NDOM) : 1;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  // All sequencer state lives in one struct so checkers can bind to seq_q directly.
  typedef struct packed {
    state_e          state;
    logic [CNTW-1:0] cnt;
    logic [IDXW-1:0] idx;
    logic [NDOM-1:0] rst;
    logic [2:0]      cause;
    logic            done;
  } seq_t;

  localparam seq_t SEQ_RST = '{
    state: ST_ASSERT,
    cnt:   '0,
    idx:   '0,
    rst:   '1,
    cause: 3'b000,
    done:  1'b0
  };

  seq_t       seq_q;
  seq_t       seq_d;
  logic       req;
  logic [2:0] reqv;

  assign req  = io_req_sw | io_req_wdt | io_req_dbg;
  assign reqv = {io_req_dbg, io_req_wdt, io_req_sw};

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      seq_q <= SEQ_RST;
    end else begin
      seq_q <= seq_d;
    end
  end

  always_comb begin
    seq_d      = seq_q;
    seq_d.done = 1'b0;
    case (seq_q.state)
      ST_ASSERT: begin
        // A request while still holding restarts the hold and accumulates causes.
        if (req) begin
          seq_d.cnt   = '0;
          seq_d.cause = seq_q.cause | reqv;
        end else if (seq_q.cnt == CNTW'(HOLD - 1)) begin
          seq_d.rst[0] = 1'b0;
          seq_d.cnt    = '0;
          if (NDOM == 1) begin
            seq_d.state = ST_RUN;
            seq_d.idx   = '0;
            seq_d.done  = 1'b1;
          end else begin
            seq_d.state = ST_RELEASE;
            seq_d.idx   = IDXW'(1);
          end
        end else begin
          seq_d.cnt = seq_q.cnt + CNTW'(1);
        end
      end

      ST_RELEASE: begin
        if (req) begin
          seq_d.state = ST_ASSERT;
          seq_d.rst   = '1;
          seq_d.cnt   = '0;
          seq_d.idx   = '0;
          seq_d.cause = reqv;
        end else if (seq_q.cnt == CNTW'(GAP - 1)) begin
          for (int i = 0; i < NDOM; i++) begin
            if (seq_q.idx == IDXW'(i)) begin
              seq_d.rst[i] = 1'b0;
            end
          end
          seq_d.cnt = '0;
          if (seq_q.idx == IDXW'(NDOM - 1)) begin
            seq_d.state = ST_RUN;
            seq_d.idx   = '0;
            seq_d.done  = 1'b1;
          end else begin
            seq_d.idx = seq_q.idx + IDXW'(1);
          end
        end else begin
          seq_d.cnt = seq_q.cnt + CNTW'(1);
        end
      end

      ST_RUN: begin
        if (req) begin
          seq_d.state = ST_ASSERT;
          seq_d.rst   = '1;
          seq_d.cnt   = '0;
          seq_d.idx   = '0;
          seq_d.cause = reqv;
        end
      end

      default: begin
        seq_d.state = ST_ASSERT;
        seq_d.rst   = '1;
        seq_d.cnt   = '0;
        seq_d.idx   = '0;
      end
    endcase
  end

  // DFT bypass drives the domain resets straight from reset_n, independent of the FSM.
  assign io_rst   = test_mode ? {NDOM{~reset_n}} : seq_q.rst;
  assign io_busy  = |seq_q.rst;
  assign io_cause = seq_q.cause;
  assign io_done  = seq_q.done;

endmodule

// File: tb/tb_ux607_reset_sequencer.sv
// Bench for ux607_reset_sequencer: directed test-plan sequences, a test-mode vector
// table and random requests, all checked against an edge-counting reference model.
module tb_ux607_reset_sequencer;

  localparam int NDOM = 3;
  localparam int HOLD = 16;
  localparam int GAP  = 4;
  localparam int CNTW = 8;
  localparam int W    = NDOM + 5;
  localparam int LAST = HOLD + (NDOM - 1) * GAP;

  // clock / reset block
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic            reset_n;
  logic            test_mode;
  logic            io_req_sw;
  logic            io_req_wdt;
  logic            io_req_dbg;
  logic [NDOM-1:0] io_rst;
  logic [2:0]      io_cause;
  logic            io_busy;
  logic            io_done;

  ux607_reset_sequencer #(
    .NDOM(NDOM), .HOLD(HOLD), .GAP(GAP), .CNTW(CNTW)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .test_mode  (test_mode),
    .io_req_sw  (io_req_sw),
    .io_req_wdt (io_req_wdt),
    .io_req_dbg (io_req_dbg),
    .io_rst     (io_rst),
    .io_cause   (io_cause),
    .io_busy    (io_busy),
    .io_done    (io_done)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model: edges since the last restart (reset or request) plus cause
  int         m_since = 0;
  logic [2:0] m_cause = 3'b000;
  logic [W-1:0] exp_q[$];

  function automatic logic [NDOM-1:0] model_rst();
    logic [NDOM-1:0] r;
    for (int i = 0; i < NDOM; i++) r[i] = (m_since < HOLD + i * GAP);
    return r;
  endfunction

  task automatic model_edge();
    logic       req;
    logic [2:0] reqv;
    logic [NDOM-1:0] mr;
    logic [NDOM-1:0] er;
    reqv = {io_req_dbg, io_req_wdt, io_req_sw};
    req  = |reqv;
    if (!reset_n) begin
      m_since = 0;
      m_cause = 3'b000;
    end else if (req) begin
      // still in the all-asserted hold window: causes accumulate, else they replace
      if (m_since < HOLD) m_cause = m_cause | reqv;
      else                m_cause = reqv;
      m_since = 0;
    end else if (m_since < 1000) begin
      m_since++;
    end
    mr = model_rst();
    er = test_mode ? {NDOM{~reset_n}} : mr;
    exp_q.push_back({er, m_cause, |mr, (m_since == LAST)});
  endtask

  task automatic compare(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: pops the model's expectation for this edge
  task automatic check_outputs();
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL sb_empty: got empty queue expected one entry");
    end else begin
      e = exp_q.pop_front();
      compare("sb_rst",   8'(io_rst),   8'(e[W-1:5]));
      compare("sb_cause", 8'(io_cause), 8'(e[4:2]));
      compare("sb_busy",  8'(io_busy),  8'(e[1]));
      compare("sb_done",  8'(io_done),  8'(e[0]));
    end
  endtask

  // driver task: inputs change on the falling edge, checks run 1 ns after the rising edge
  task automatic step(input logic sw, input logic wdt, input logic dbg,
                      input logic rn, input logic tm);
    @(negedge clock);
    io_req_sw  = sw;
    io_req_wdt = wdt;
    io_req_dbg = dbg;
    reset_n    = rn;
    test_mode  = tm;
    @(posedge clock);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  function automatic logic [2:0] release_pattern(input int k);
    if (k < 16)      return 3'b111;
    else if (k < 20) return 3'b110;
    else if (k < 24) return 3'b100;
    else             return 3'b000;
  endfunction

  typedef struct {
    logic       tm;
    logic       rn;
    logic       sw;
    logic [2:0] exp_rst;
  } tm_vec_t;

  tm_vec_t tm_tbl[6];

  initial begin
    int dones;
    reset_n    = 1'b0;
    test_mode  = 1'b0;
    io_req_sw  = 1'b0;
    io_req_wdt = 1'b0;
    io_req_dbg = 1'b0;

    tm_tbl[0] = '{tm: 1'b1, rn: 1'b1, sw: 1'b0, exp_rst: 3'b000};
    tm_tbl[1] = '{tm: 1'b1, rn: 1'b0, sw: 1'b0, exp_rst: 3'b111};
    tm_tbl[2] = '{tm: 1'b1, rn: 1'b1, sw: 1'b0, exp_rst: 3'b000};
    tm_tbl[3] = '{tm: 1'b1, rn: 1'b1, sw: 1'b1, exp_rst: 3'b000};
    tm_tbl[4] = '{tm: 1'b1, rn: 1'b0, sw: 1'b1, exp_rst: 3'b111};
    tm_tbl[5] = '{tm: 1'b1, rn: 1'b1, sw: 1'b0, exp_rst: 3'b000};

    // power-on
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    compare("reset_rst",   8'(io_rst),   8'h07);
    compare("reset_busy",  8'(io_busy),  8'h01);
    compare("reset_cause", 8'(io_cause), 8'h00);
    compare("reset_done",  8'(io_done),  8'h00);
    for (int k = 1; k <= 30; k++) begin
      idle(1);
      compare("po_rst",  8'(io_rst),  8'(release_pattern(k)));
      compare("po_done", 8'(io_done), 8'(k == 24));
    end
    compare("po_cause", 8'(io_cause), 8'h00);

    // watchdog pulse in RUN
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    compare("wdt_rst",   8'(io_rst),   8'h07);
    compare("wdt_busy",  8'(io_busy),  8'h01);
    compare("wdt_cause", 8'(io_cause), 8'h02);
    dones = 0;
    for (int k = 1; k <= 30; k++) begin
      idle(1);
      if (io_done) dones++;
      compare("wdt_release", 8'(io_rst), 8'(release_pattern(k)));
    end
    compare("wdt_done_count", 8'(dones), 8'h01);

    // software request mid-RELEASE aborts the sequence
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(17);
    compare("sw_pre_rst", 8'(io_rst), 8'h06);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    compare("sw_rst",   8'(io_rst),   8'h07);
    compare("sw_cause", 8'(io_cause), 8'h01);
    dones = 0;
    for (int k = 1; k <= 16; k++) begin
      idle(1);
      if (io_done) dones++;
      compare("sw_hold", 8'(io_rst), (k < 16) ? 8'h07 : 8'h06);
    end
    compare("sw_no_done", 8'(dones), 8'h00);
    idle(12);

    // simultaneous sw+dbg at cnt=10 after a watchdog reset
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(10);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    compare("sim_cause", 8'(io_cause), 8'h07);
    for (int k = 1; k <= 16; k++) begin
      idle(1);
      compare("sim_hold", 8'(io_rst), (k < 16) ? 8'h07 : 8'h06);
    end
    idle(12);

    // reset_n mid-RELEASE
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(21);
    compare("rn_pre_rst",   8'(io_rst),   8'h04);
    compare("rn_pre_cause", 8'(io_cause), 8'h02);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    compare("rn_rst",   8'(io_rst),   8'h07);
    compare("rn_cause", 8'(io_cause), 8'h00);
    for (int k = 1; k <= 30; k++) begin
      idle(1);
      compare("rn_po_rst",  8'(io_rst),  8'(release_pattern(k)));
      compare("rn_po_done", 8'(io_done), 8'(k == 24));
    end

    // test-mode bypass vectors (combinational check before each edge)
    foreach (tm_tbl[i]) begin
      @(negedge clock);
      test_mode  = tm_tbl[i].tm;
      reset_n    = tm_tbl[i].rn;
      io_req_sw  = tm_tbl[i].sw;
      io_req_wdt = 1'b0;
      io_req_dbg = 1'b0;
      #1;
      compare("tm_comb_rst", 8'(io_rst), 8'(tm_tbl[i].exp_rst));
      @(posedge clock);
      model_edge();
      #1;
      check_outputs();
    end
    idle(30);

    // randomized requests, resets and occasional bypass
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 39) == 0, $urandom_range(0, 99) != 0,
           $urandom_range(0, 19) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
